// File: rtl/alu_ram_pkg.sv
// Shared types and constants for the ALU-RAM program sequencer.
// The HOLD state exists only when SINGLE_STEP_EN is defined.
package alu_ram_pkg;

  localparam int ROM_AW_DEF    = 4;
  localparam int RAM_AW_DEF    = 4;
  localparam int DW_DEF        = 8;
  localparam int OP_W_DEF      = 4;
  localparam int LAST_ADDR_DEF = 13;

  // ROM word layout: {op, dst, srcA, srcB}, each field 4 bits wide
  localparam int FIELD_W  = 4;
  localparam int OP_LSB   = 12;
  localparam int DST_LSB  = 8;
  localparam int SRCA_LSB = 4;
  localparam int SRCB_LSB = 0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_RD_A,
    S_RD_B,
    S_LAT_B,
    S_WB,
    S_DONE
`ifdef SINGLE_STEP_EN
    , S_HOLD
`endif
  } state_e;

  function automatic logic [FIELD_W-1:0] rom_field(input logic [15:0] word, input int lsb);
    return word[lsb +: FIELD_W];
  endfunction

endpackage

// File: rtl/alu_ram_pc.sv
// Program counter for the sequencer: clear, saturating increment, last-address flag.
module alu_ram_pc #(
  parameter int ROM_AW    = 4,
  parameter int LAST_ADDR = 13
) (
  input  logic              CP,
  input  logic              nRST,
  input  logic              clr,
  input  logic              inc,
  output logic [ROM_AW-1:0] pc,
  output logic              is_last
);

  localparam logic [ROM_AW-1:0] LAST_PC = ROM_AW'(LAST_ADDR);

  logic [ROM_AW-1:0] pc_q, pc_d;

  // The counter never moves past LAST_PC; the end-of-run clear takes it back to 0.
  always_comb begin
    pc_d = pc_q;
    if (clr) begin
      pc_d = '0;
    end else if (inc && (pc_q != LAST_PC)) begin
      pc_d = pc_q + ROM_AW'(1);
    end
  end

  always_ff @(posedge CP or negedge nRST) begin
    if (!nRST) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc      = pc_q;
  assign is_last = (pc_q == LAST_PC);

endmodule

// File: rtl/alu_ram_sequencer.sv
// Start/busy/done program sequencer: fetch, decode, two RAM reads, ALU write-back per ROM word.
// Define SINGLE_STEP_EN to add the step input and park in HOLD after every write-back.
module alu_ram_sequencer
  import alu_ram_pkg::*;
#(
  parameter int ROM_AW    = ROM_AW_DEF,
  parameter int RAM_AW    = RAM_AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int OP_W      = OP_W_DEF,
  parameter int LAST_ADDR = LAST_ADDR_DEF
) (
  input  logic              CP,
  input  logic              nRST,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              en_ROM,
  output logic [ROM_AW-1:0] s_addr_ROM,
  input  logic [15:0]       d_ROM,
  output logic              en_RAM,
  output logic              we_RAM,
  output logic [RAM_AW-1:0] addr_RAM,
  output logic [DW-1:0]     din_RAM,
  input  logic [DW-1:0]     dout_RAM,
  output logic [OP_W-1:0]   op_ALU,
  output logic [DW-1:0]     a_ALU,
  output logic [DW-1:0]     b_ALU,
  input  logic [DW-1:0]     y_ALU,
`ifdef SINGLE_STEP_EN
  input  logic              step,
`endif
  output state_e            dbg_state
);

  // Handshake: start is a level sampled only in S_IDLE; busy covers the whole run and
  // done is a single-cycle pulse in S_DONE, after which start is sampled again.

  state_e            state_q, state_d;
  logic [15:0]       ir_q, ir_d;
  logic [DW-1:0]     a_q, a_d, b_q, b_d;
  logic [ROM_AW-1:0] pc;
  logic [ROM_AW-1:0] s_addr_rom_q, s_addr_rom_d;
  logic [RAM_AW-1:0] addr_ram_q, addr_ram_d;
  logic [DW-1:0]     din_ram_q, din_ram_d;
  logic [OP_W-1:0]   op_alu_q, op_alu_d;
  logic [DW-1:0]     a_alu_q, a_alu_d, b_alu_q, b_alu_d;
  logic              pc_inc, pc_clr, pc_last;

  alu_ram_pc #(
    .ROM_AW    (ROM_AW),
    .LAST_ADDR (LAST_ADDR)
  ) u_pc (
    .CP      (CP),
    .nRST    (nRST),
    .clr     (pc_clr),
    .inc     (pc_inc),
    .pc      (pc),
    .is_last (pc_last)
  );

  always_comb begin
    state_d = state_q;
    pc_inc  = 1'b0;
    pc_clr  = 1'b0;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_RD_A;
      S_RD_A:   state_d = S_RD_B;
      S_RD_B:   state_d = S_LAT_B;
      S_LAT_B:  state_d = S_WB;
`ifdef SINGLE_STEP_EN
      S_WB:     state_d = S_HOLD;
      S_HOLD: begin
        if (step) begin
          state_d = pc_last ? S_DONE : S_FETCH;
          pc_inc  = 1'b1;
        end
      end
`else
      S_WB: begin
        state_d = pc_last ? S_DONE : S_FETCH;
        pc_inc  = 1'b1;
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
        pc_clr  = 1'b1;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Address/data/op outputs take a new value only in the state that owns them and
  // otherwise replay the registered copy, so they hold between uses.
  always_comb begin
    ir_d         = (state_q == S_DECODE) ? d_ROM : ir_q;
    a_d          = (state_q == S_RD_B) ? dout_RAM : a_q;
    b_d          = (state_q == S_LAT_B) ? dout_RAM : b_q;
    s_addr_rom_d = (state_q == S_FETCH) ? pc : s_addr_rom_q;
    addr_ram_d   = addr_ram_q;
    din_ram_d    = din_ram_q;
    op_alu_d     = op_alu_q;
    a_alu_d      = a_alu_q;
    b_alu_d      = b_alu_q;
    case (state_q)
      S_RD_A: addr_ram_d = RAM_AW'(rom_field(ir_q, SRCA_LSB));
      S_RD_B: addr_ram_d = RAM_AW'(rom_field(ir_q, SRCB_LSB));
      S_WB: begin
        addr_ram_d = RAM_AW'(rom_field(ir_q, DST_LSB));
        op_alu_d   = OP_W'(rom_field(ir_q, OP_LSB));
        a_alu_d    = a_q;
        b_alu_d    = b_q;
        din_ram_d  = y_ALU;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CP or negedge nRST) begin
    if (!nRST) begin
      state_q      <= S_IDLE;
      ir_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      s_addr_rom_q <= '0;
      addr_ram_q   <= '0;
      din_ram_q    <= '0;
      op_alu_q     <= '0;
      a_alu_q      <= '0;
      b_alu_q      <= '0;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      a_q          <= a_d;
      b_q          <= b_d;
      s_addr_rom_q <= s_addr_rom_d;
      addr_ram_q   <= addr_ram_d;
      din_ram_q    <= din_ram_d;
      op_alu_q     <= op_alu_d;
      a_alu_q      <= a_alu_d;
      b_alu_q      <= b_alu_d;
    end
  end

  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign en_ROM     = (state_q == S_FETCH);
  assign en_RAM     = (state_q == S_RD_A) || (state_q == S_RD_B) || (state_q == S_WB);
  assign we_RAM     = (state_q == S_WB);
  assign s_addr_ROM = s_addr_rom_d;
  assign addr_RAM   = addr_ram_d;
  assign din_RAM    = din_ram_d;
  assign op_ALU     = op_alu_d;
  assign a_ALU      = a_alu_d;
  assign b_ALU      = b_alu_d;
  assign dbg_state  = state_q;

endmodule
